divide_by_power_of_two_seq: RTL and testbench

- Iterative divide-by-power-of-two unit. It is the inverse of the combinational multiply-by-power-of-two left shifter.
- Accepts an N-bit operand and an exponent over a valid/ready handshake.
- Right-shifts the operand one bit per clock, collecting the shifted-out bits as a remainder.
- Returns quotient and remainder over a second valid/ready handshake. Used wherever a normalised value must be scaled back down without a full barrel shifter.

---
 rtl/divide_by_power_of_two_seq.sv | 115 +++++++++++
 tb/tb_divide_by_power_of_two_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/divide_by_power_of_two_seq.sv
// Iterative divide-by-power-of-two unit.
// Accepts an operand and an exponent E. It then right-shifts the operand one
// bit per clock and gathers the shifted-out bits into a remainder. The
// quotient/remainder pair is presented on a valid/ready output handshake.
module divide_by_power_of_two_seq #(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         data_in,
  input  logic [$clog2(N)-1:0] base2exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         quotient,
  output logic [N-1:0]         remainder
);

  localparam int EW = $clog2(N);
  // The bit index can reach N. Writes stop once all N operand bits have been
  // captured. For E >= N, the extra shifts then cannot overwrite the top
  // remainder bit with fill bits.
  localparam int KW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [EW-1:0]   count_q, count_d;
  logic [KW-1:0]   k_q, k_d;
  // live_q holds in_ready low during reset.
  // It lets in_ready rise only after the first clock with rstN high.
  logic            live_q;
  logic            fill;

  // The bit shifted into the vacated MSB: zero when unsigned, the sign bit when signed.
  assign fill = SIGNED ? quot_q[N-1] : 1'b0;

  // Next-state logic, datapath updates and handshake outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    count_d   = count_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = live_q;
        if (in_valid && live_q) begin
          quot_d  = data_in;
          rem_d   = '0;
          count_d = base2exp;
          k_d     = '0;
          state_d = (base2exp != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        quot_d = {fill, quot_q[N-1:1]};
        if (k_q < KW'(N)) begin
          for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) rem_d[i] = quot_q[0];
          end
          k_d = k_q + 1'b1;
        end
        count_d = count_q - 1'b1;
        if (count_q == EW'(1)) state_d = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; every register is cleared.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // update together at the edge, whatever order the statements are in.
    if (!rstN) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      count_q <= '0;
      k_q     <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      k_q     <= k_d;
      live_q  <= 1'b1;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_divide_by_power_of_two_seq.sv
// Directed bench for divide_by_power_of_two_seq.
// One unsigned (u) instance and one signed (s) instance share all inputs.
module tb_divide_by_power_of_two_seq;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] base2exp = 3'd0;

  logic       in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [7:0] q_u, r_u, q_s, r_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divide_by_power_of_two_seq #(.N(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready_u),
    .data_in(data_in), .base2exp(base2exp), .out_valid(out_valid_u),
    .out_ready(out_ready), .quotient(q_u), .remainder(r_u)
  );

  divide_by_power_of_two_seq #(.N(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready_s),
    .data_in(data_in), .base2exp(base2exp), .out_valid(out_valid_s),
    .out_ready(out_ready), .quotient(q_s), .remainder(r_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand, wait (bounded) for in_ready, accept on the next edge.
  task automatic send(input logic [7:0] d, input logic [2:0] e, input string name);
    int guard = 0;
    data_in  = d;
    base2exp = e;
    in_valid = 1'b1;
    while (!in_ready_u && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (in_ready_u !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready got %b need 1", name, in_ready_u);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts the accept cycle as 1. Also records any in_ready while waiting.
  task automatic wait_out(output int lat, output bit ready_seen);
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid_u && lat < 50) begin
      if (in_ready_u) ready_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick();
    tick();
    checks++; if (in_ready_u !== 1'b0) begin errors++; $display("FAIL rst_in_ready_u: got %b need 0", in_ready_u); end
    checks++; if (in_ready_s !== 1'b0) begin errors++; $display("FAIL rst_in_ready_s: got %b need 0", in_ready_s); end
    checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid_u); end
    checks++; if (q_u !== 8'h00) begin errors++; $display("FAIL rst_quotient: got %h need 00", q_u); end
    checks++; if (r_u !== 8'h00) begin errors++; $display("FAIL rst_remainder: got %h need 00", r_u); end
    rstN = 1'b1;
    tick();
    checks++; if (in_ready_u !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b need 1", in_ready_u); end
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b need 0", out_valid_s); end
  endtask

  task automatic test_basic();
    int lat;
    bit rdy;
    send(8'hB5, 3'd3, "basic");
    wait_out(lat, rdy);
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d need 4", lat); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_ready_busy: got %b need 0", rdy); end
    checks++; if (q_u !== 8'h16) begin errors++; $display("FAIL basic_q_u: got %h need 16", q_u); end
    checks++; if (r_u !== 8'h05) begin errors++; $display("FAIL basic_r_u: got %h need 05", r_u); end
    checks++; if (q_s !== 8'hF6) begin errors++; $display("FAIL basic_q_s: got %h need f6", q_s); end
    checks++; if (r_s !== 8'h05) begin errors++; $display("FAIL basic_r_s: got %h need 05", r_s); end
    handshake();
    checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b need 0", out_valid_u); end
    checks++; if (in_ready_u !== 1'b1) begin errors++; $display("FAIL basic_ready_rise: got %b need 1", in_ready_u); end
  endtask

  task automatic test_exp_zero();
    int lat;
    bit rdy;
    send(8'h5A, 3'd0, "exp0");
    wait_out(lat, rdy);
    checks++; if (lat != 1) begin errors++; $display("FAIL exp0_latency: got %0d need 1", lat); end
    checks++; if (q_u !== 8'h5A) begin errors++; $display("FAIL exp0_q_u: got %h need 5a", q_u); end
    checks++; if (r_u !== 8'h00) begin errors++; $display("FAIL exp0_r_u: got %h need 00", r_u); end
    checks++; if (q_s !== 8'h5A) begin errors++; $display("FAIL exp0_q_s: got %h need 5a", q_s); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit rdy;
    send(8'hFF, 3'd7, "b2b_a");
    wait_out(lat, rdy);
    checks++; if (lat != 8) begin errors++; $display("FAIL b2b_a_latency: got %0d need 8", lat); end
    checks++; if (q_u !== 8'h01) begin errors++; $display("FAIL b2b_a_q_u: got %h need 01", q_u); end
    checks++; if (r_u !== 8'h7F) begin errors++; $display("FAIL b2b_a_r_u: got %h need 7f", r_u); end
    checks++; if (q_s !== 8'hFF) begin errors++; $display("FAIL b2b_a_q_s: got %h need ff", q_s); end
    checks++; if (r_s !== 8'h7F) begin errors++; $display("FAIL b2b_a_r_s: got %h need 7f", r_s); end
    checks++; if (in_ready_u !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b need 0", in_ready_u); end
    handshake();
    checks++; if (in_ready_u !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_hs: got %b need 1", in_ready_u); end
    send(8'h80, 3'd7, "b2b_b");
    wait_out(lat, rdy);
    checks++; if (lat != 8) begin errors++; $display("FAIL b2b_b_latency: got %0d need 8", lat); end
    checks++; if (q_u !== 8'h01) begin errors++; $display("FAIL b2b_b_q_u: got %h need 01", q_u); end
    checks++; if (r_u !== 8'h00) begin errors++; $display("FAIL b2b_b_r_u: got %h need 00", r_u); end
    checks++; if (q_s !== 8'hFF) begin errors++; $display("FAIL b2b_b_q_s: got %h need ff", q_s); end
    checks++; if (r_s !== 8'h00) begin errors++; $display("FAIL b2b_b_r_s: got %h need 00", r_s); end
    handshake();
  endtask

  task automatic test_signed();
    int lat;
    bit rdy;
    send(8'hB5, 3'd2, "signed");
    wait_out(lat, rdy);
    checks++; if (lat != 3) begin errors++; $display("FAIL signed_latency: got %0d need 3", lat); end
    checks++; if (q_s !== 8'hED) begin errors++; $display("FAIL signed_q_s: got %h need ed", q_s); end
    checks++; if (r_s !== 8'h01) begin errors++; $display("FAIL signed_r_s: got %h need 01", r_s); end
    checks++; if (q_u !== 8'h2D) begin errors++; $display("FAIL signed_q_u: got %h need 2d", q_u); end
    checks++; if (r_u !== 8'h01) begin errors++; $display("FAIL signed_r_u: got %h need 01", r_u); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy;
    send(8'h3C, 3'd1, "bp");
    wait_out(lat, rdy);
    checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency: got %0d need 2", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      data_in  = 8'hC3 ^ 8'(i);
      base2exp = 3'd0;
      tick();
      checks++; if (out_valid_u !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b need 1", i, out_valid_u); end
      checks++; if (in_ready_u !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b need 0", i, in_ready_u); end
      checks++; if (q_u !== 8'h1E) begin errors++; $display("FAIL bp_q_u_%0d: got %h need 1e", i, q_u); end
      checks++; if (r_u !== 8'h00) begin errors++; $display("FAIL bp_r_u_%0d: got %h need 00", i, r_u); end
      checks++; if (q_s !== 8'h1E) begin errors++; $display("FAIL bp_q_s_%0d: got %h need 1e", i, q_s); end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b need 0", out_valid_u); end
    checks++; if (in_ready_u !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b need 1", in_ready_u); end
  endtask

  task automatic test_reset_mid_shift();
    bit stale = 1'b0;
    send(8'h77, 3'd5, "midrst");
    tick();
    rstN = 1'b0;
    tick();
    checks++; if (out_valid_u !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b need 0", out_valid_u); end
    checks++; if (q_u !== 8'h00) begin errors++; $display("FAIL midrst_q_u: got %h need 00", q_u); end
    checks++; if (r_u !== 8'h00) begin errors++; $display("FAIL midrst_r_u: got %h need 00", r_u); end
    checks++; if (q_s !== 8'h00) begin errors++; $display("FAIL midrst_q_s: got %h need 00", q_s); end
    checks++; if (in_ready_u !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %b need 0", in_ready_u); end
    tick();
    checks++; if (in_ready_s !== 1'b0) begin errors++; $display("FAIL midrst_ready_hold: got %b need 0", in_ready_s); end
    rstN = 1'b1;
    tick();
    checks++; if (in_ready_u !== 1'b1) begin errors++; $display("FAIL midrst_ready_release: got %b need 1", in_ready_u); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid_u || out_valid_s) stale = 1'b1;
      tick();
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale_valid: got %b need 0", stale); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_exp_zero();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
